// File: rtl/trap_sequencer.sv
// Trap / mret sequencer for the writeback stage.
// Detects a timer interrupt, ecall or mret on the instruction in writeback.
// In that same cycle it raises the CSR strobe and flushes the pipeline.
// The fetch target is then held in redirect_pc until fetch accepts it.
module trap_sequencer #(
    parameter int VECTORED_EN = 1,
    parameter int TIMER_CAUSE = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_ecall,
    input  logic        wb_mret,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        mtip,
    input  logic [63:0] mtvec,
    input  logic [63:0] mepc,
    output logic        trap_take,
    output logic        mret_take,
    output logic [63:0] trap_epc,
    output logic [63:0] trap_cause,
    output logic        kill_wb,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy,
    output logic [31:0] trap_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    localparam logic [62:0] TIMER_CODE = 63'(TIMER_CAUSE);
    localparam logic [31:0] VEC_OFFSET = 32'(TIMER_CAUSE * 4);
    localparam logic [63:0] ECALL_CODE = 64'd11;

    state_t      state_reg;
    logic        redirect_valid_reg;
    logic [31:0] redirect_pc_reg;
    logic [31:0] trap_count_reg;

    logic        is_idle;
    logic        int_pend;
    logic        ev_int;
    logic        ev_ecall;
    logic        ev_mret;
    logic        ev_any;
    logic [31:0] trap_base;
    logic        use_vector;
    logic [31:0] target_next;

    // Upper halves of the CSRs never reach a 32-bit fetch address.
    logic unused_bits;
    assign unused_bits = ^{mtvec[63:32], mepc[63:32]};

    assign is_idle  = (state_reg == IDLE);
    assign int_pend = mstatus_mie & mie_mtie & mtip;

    // Fixed priority: interrupt, then ecall, then mret; only one can fire.
    assign ev_int   = is_idle & wb_valid & int_pend;
    assign ev_ecall = is_idle & wb_valid & ~int_pend & wb_ecall;
    assign ev_mret  = is_idle & wb_valid & ~int_pend & ~wb_ecall & wb_mret;
    assign ev_any   = ev_int | ev_ecall | ev_mret;

    // Mode 2'b01 is vectored; every other mode value (including 2'b1x) is direct.
    assign trap_base  = {mtvec[31:2], 2'b00};
    assign use_vector = (VECTORED_EN != 0) && ev_int && (mtvec[1:0] == 2'b01);

    // Select the fetch target for whichever event fires this cycle.
    always_comb begin
        target_next = trap_base;
        if (ev_mret) begin
            target_next = mepc[31:0];
        end else if (use_vector) begin
            target_next = trap_base + VEC_OFFSET;
        end
    end

    // CSR strobe values; cause and epc are zero whenever no trap is taken.
    always_comb begin
        trap_cause = 64'd0;
        trap_epc   = 64'd0;
        if (ev_int) begin
            trap_cause = {1'b1, TIMER_CODE};
            trap_epc   = {32'd0, wb_pc};
        end else if (ev_ecall) begin
            trap_cause = ECALL_CODE;
            trap_epc   = {32'd0, wb_pc};
        end
    end

    assign trap_take      = ev_int | ev_ecall;
    assign mret_take      = ev_mret;
    assign kill_wb        = ev_int;
    assign flush          = ev_any | (state_reg == REDIR);
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign busy           = (state_reg == REDIR);
    assign trap_count     = trap_count_reg;

    // Sequencer state, held redirect target and trap counter; reset wins over events.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= 32'd0;
            trap_count_reg     <= 32'd0;
        end else begin
            if (trap_take) begin
                trap_count_reg <= trap_count_reg + 32'd1;
            end
            case (state_reg)
                IDLE: begin
                    if (ev_any) begin
                        state_reg          <= REDIR;
                        redirect_valid_reg <= 1'b1;
                        redirect_pc_reg    <= target_next;
                    end
                end
                REDIR: begin
                    if (redirect_ready) begin
                        state_reg          <= IDLE;
                        redirect_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg          <= IDLE;
                    redirect_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a vector table of single events plus
// hand-written sequences for stall, back-to-back, reset and counter wrap.
module tb_trap_sequencer;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_ecall;
    logic        wb_mret;
    logic        mstatus_mie;
    logic        mie_mtie;
    logic        mtip;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    logic        trap_take;
    logic        mret_take;
    logic [63:0] trap_epc;
    logic [63:0] trap_cause;
    logic        kill_wb;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;
    logic [31:0] trap_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_count;

    localparam logic [63:0] C_INT = 64'h8000_0000_0000_0007;
    localparam logic [63:0] C_EC  = 64'd11;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        ecall;
        logic        mret;
        logic        mie;
        logic        mtie;
        logic        mtip;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        logic        e_trap;
        logic        e_mret;
        logic        e_kill;
        logic        e_event;
        logic [63:0] e_cause;
        logic [63:0] e_epc;
        logic [31:0] e_target;
    } vec_t;

    vec_t vecs[15];

    trap_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_pc          (wb_pc),
        .wb_ecall       (wb_ecall),
        .wb_mret        (wb_mret),
        .mstatus_mie    (mstatus_mie),
        .mie_mtie       (mie_mtie),
        .mtip           (mtip),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .trap_take      (trap_take),
        .mret_take      (mret_take),
        .trap_epc       (trap_epc),
        .trap_cause     (trap_cause),
        .kill_wb        (kill_wb),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .busy           (busy),
        .trap_count     (trap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, input logic ec, input logic mr,
        input logic ie, input logic te, input logic tp,
        input logic [63:0] tv, input logic [63:0] ep,
        input logic xt, input logic xm, input logic xk, input logic xe,
        input logic [63:0] xc, input logic [63:0] xp, input logic [31:0] xg);
        vec_t r;
        r.valid = v;  r.pc = pc;  r.ecall = ec;  r.mret = mr;
        r.mie = ie;   r.mtie = te; r.mtip = tp;
        r.mtvec = tv; r.mepc = ep;
        r.e_trap = xt; r.e_mret = xm; r.e_kill = xk; r.e_event = xe;
        r.e_cause = xc; r.e_epc = xp; r.e_target = xg;
        return r;
    endfunction

    task automatic clear_wb();
        wb_valid = 1'b0; wb_pc = 32'd0; wb_ecall = 1'b0; wb_mret = 1'b0;
        mstatus_mie = 1'b0; mie_mtie = 1'b0; mtip = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(1, 32'h8000_0100, 1, 0, 0, 0, 0, 64'h8000_1000, 64'h0,
                      1, 0, 0, 1, C_EC, 64'h8000_0100, 32'h8000_1000);
        vecs[1]  = mk(1, 32'h8000_0200, 0, 0, 1, 1, 1, 64'h8000_1001, 64'h0,
                      1, 0, 1, 1, C_INT, 64'h8000_0200, 32'h8000_101C);
        vecs[2]  = mk(1, 32'h8000_0300, 0, 1, 1, 1, 1, 64'h8000_1001, 64'h8000_0040,
                      1, 0, 1, 1, C_INT, 64'h8000_0300, 32'h8000_101C);
        vecs[3]  = mk(1, 32'h8000_0400, 0, 1, 0, 0, 0, 64'h8000_1001, 64'h8000_0040,
                      0, 1, 0, 1, 64'h0, 64'h0, 32'h8000_0040);
        vecs[4]  = mk(1, 32'h8000_0500, 1, 0, 0, 0, 0, 64'h8000_1001, 64'h0,
                      1, 0, 0, 1, C_EC, 64'h8000_0500, 32'h8000_1000);
        vecs[5]  = mk(1, 32'h8000_0600, 0, 0, 1, 1, 1, 64'h8000_1003, 64'h0,
                      1, 0, 1, 1, C_INT, 64'h8000_0600, 32'h8000_1000);
        vecs[6]  = mk(1, 32'h8000_0700, 0, 0, 1, 1, 1, 64'h8000_2002, 64'h0,
                      1, 0, 1, 1, C_INT, 64'h8000_0700, 32'h8000_2000);
        vecs[7]  = mk(0, 32'h8000_0800, 1, 1, 1, 1, 1, 64'h8000_1001, 64'h8000_0040,
                      0, 0, 0, 0, 64'h0, 64'h0, 32'h0);
        vecs[8]  = mk(1, 32'h8000_0900, 0, 0, 0, 1, 1, 64'h8000_1001, 64'h0,
                      0, 0, 0, 0, 64'h0, 64'h0, 32'h0);
        vecs[9]  = mk(1, 32'h8000_0A00, 1, 0, 1, 0, 1, 64'h8000_1001, 64'h0,
                      1, 0, 0, 1, C_EC, 64'h8000_0A00, 32'h8000_1000);
        vecs[10] = mk(1, 32'h8000_0B00, 1, 1, 0, 0, 0, 64'h8000_1000, 64'h8000_0040,
                      1, 0, 0, 1, C_EC, 64'h8000_0B00, 32'h8000_1000);
        vecs[11] = mk(1, 32'h8000_0C00, 0, 0, 1, 1, 1, 64'hFFFF_0000_8000_3005, 64'h0,
                      1, 0, 1, 1, C_INT, 64'h8000_0C00, 32'h8000_3020);
        vecs[12] = mk(1, 32'h8000_0D00, 0, 1, 0, 0, 0, 64'h8000_1000, 64'h1234_5678_9ABC_DEF0,
                      0, 1, 0, 1, 64'h0, 64'h0, 32'h9ABC_DEF0);
        vecs[13] = mk(1, 32'h8000_0E00, 0, 0, 0, 0, 0, 64'h8000_1000, 64'h0,
                      0, 0, 0, 0, 64'h0, 64'h0, 32'h0);
        vecs[14] = mk(1, 32'h8000_0F00, 0, 1, 1, 1, 0, 64'h8000_1000, 64'h8000_0044,
                      0, 1, 0, 1, 64'h0, 64'h0, 32'h8000_0044);

        // Reset
        rst = 1'b1;
        clear_wb();
        mtvec = 64'h0; mepc = 64'h0; redirect_ready = 1'b0;
        model_count = 32'd0;
        next_cycle();
        next_cycle();
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset redirect_valid", {63'd0, redirect_valid}, 64'd0);
        chk("reset redirect_pc", {32'd0, redirect_pc}, 64'd0);
        chk("reset trap_count", {32'd0, trap_count}, 64'd0);
        rst = 1'b0;
        next_cycle();

        // Single-event vectors, each returned to IDLE afterwards
        for (int i = 0; i < 15; i++) begin
            wb_valid = vecs[i].valid; wb_pc = vecs[i].pc;
            wb_ecall = vecs[i].ecall; wb_mret = vecs[i].mret;
            mstatus_mie = vecs[i].mie; mie_mtie = vecs[i].mtie; mtip = vecs[i].mtip;
            mtvec = vecs[i].mtvec; mepc = vecs[i].mepc;
            redirect_ready = 1'b0;
            #2;
            chk($sformatf("vec%0d trap_take", i), {63'd0, trap_take}, {63'd0, vecs[i].e_trap});
            chk($sformatf("vec%0d mret_take", i), {63'd0, mret_take}, {63'd0, vecs[i].e_mret});
            chk($sformatf("vec%0d kill_wb", i), {63'd0, kill_wb}, {63'd0, vecs[i].e_kill});
            chk($sformatf("vec%0d flush", i), {63'd0, flush}, {63'd0, vecs[i].e_event});
            chk($sformatf("vec%0d trap_cause", i), trap_cause, vecs[i].e_cause);
            chk($sformatf("vec%0d trap_epc", i), trap_epc, vecs[i].e_epc);
            if (vecs[i].e_trap) model_count = model_count + 32'd1;
            next_cycle();
            clear_wb();
            chk($sformatf("vec%0d busy", i), {63'd0, busy}, {63'd0, vecs[i].e_event});
            chk($sformatf("vec%0d redirect_valid", i), {63'd0, redirect_valid}, {63'd0, vecs[i].e_event});
            chk($sformatf("vec%0d trap_count", i), {32'd0, trap_count}, {32'd0, model_count});
            if (vecs[i].e_event) begin
                chk($sformatf("vec%0d redirect_pc", i), {32'd0, redirect_pc}, {32'd0, vecs[i].e_target});
                redirect_ready = 1'b1;
                next_cycle();
                redirect_ready = 1'b0;
                chk($sformatf("vec%0d exit busy", i), {63'd0, busy}, 64'd0);
                chk($sformatf("vec%0d exit redirect_valid", i), {63'd0, redirect_valid}, 64'd0);
            end
        end

        // Mret with fetch stalled for 5 cycles; ecall pulses in REDIR are ignored
        wb_valid = 1'b1; wb_mret = 1'b1; wb_pc = 32'h8000_1200;
        mepc = 64'h8000_0040; mtvec = 64'h8000_1000; redirect_ready = 1'b0;
        #2;
        chk("stall mret_take", {63'd0, mret_take}, 64'd1);
        next_cycle();
        wb_mret = 1'b0;
        for (int c = 0; c < 5; c++) begin
            wb_valid = 1'b1;
            wb_ecall = (c % 2 == 0);
            #2;
            chk($sformatf("stall%0d trap_take", c), {63'd0, trap_take}, 64'd0);
            chk($sformatf("stall%0d mret_take", c), {63'd0, mret_take}, 64'd0);
            chk($sformatf("stall%0d flush", c), {63'd0, flush}, 64'd1);
            chk($sformatf("stall%0d redirect_valid", c), {63'd0, redirect_valid}, 64'd1);
            chk($sformatf("stall%0d redirect_pc", c), {32'd0, redirect_pc}, 64'h8000_0040);
            next_cycle();
        end
        clear_wb();
        redirect_ready = 1'b1;
        #2;
        chk("stall release busy", {63'd0, busy}, 64'd1);
        next_cycle();
        redirect_ready = 1'b0;
        chk("stall exit busy", {63'd0, busy}, 64'd0);
        chk("stall exit redirect_valid", {63'd0, redirect_valid}, 64'd0);
        chk("stall trap_count", {32'd0, trap_count}, {32'd0, model_count});

        // Ready held high: ignored in IDLE, 2-cycle latency, back-to-back event
        redirect_ready = 1'b1;
        wb_valid = 1'b1; wb_ecall = 1'b1; wb_pc = 32'h8000_1100; mtvec = 64'h8000_1000;
        #2;
        chk("b2b first trap_take", {63'd0, trap_take}, 64'd1);
        model_count = model_count + 32'd1;
        next_cycle();
        clear_wb();
        chk("b2b first busy", {63'd0, busy}, 64'd1);
        next_cycle();
        chk("b2b exit busy", {63'd0, busy}, 64'd0);
        wb_valid = 1'b1; mstatus_mie = 1'b1; mie_mtie = 1'b1; mtip = 1'b1;
        wb_pc = 32'h8000_1104; mtvec = 64'h8000_1001;
        #2;
        chk("b2b second trap_take", {63'd0, trap_take}, 64'd1);
        chk("b2b second kill_wb", {63'd0, kill_wb}, 64'd1);
        model_count = model_count + 32'd1;
        next_cycle();
        clear_wb();
        chk("b2b second busy", {63'd0, busy}, 64'd1);
        chk("b2b second redirect_pc", {32'd0, redirect_pc}, 64'h8000_101C);
        next_cycle();
        redirect_ready = 1'b0;
        chk("b2b second exit busy", {63'd0, busy}, 64'd0);
        chk("b2b trap_count", {32'd0, trap_count}, {32'd0, model_count});

        // Reset while in REDIR abandons the redirect
        wb_valid = 1'b1; wb_ecall = 1'b1; wb_pc = 32'h8000_1300; mtvec = 64'h8000_1000;
        next_cycle();
        clear_wb();
        chk("rst-redir entered busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        next_cycle();
        model_count = 32'd0;
        chk("rst-redir redirect_valid", {63'd0, redirect_valid}, 64'd0);
        chk("rst-redir busy", {63'd0, busy}, 64'd0);
        chk("rst-redir trap_count", {32'd0, trap_count}, 64'd0);
        chk("rst-redir redirect_pc", {32'd0, redirect_pc}, 64'd0);

        // Event coinciding with reset is discarded
        wb_valid = 1'b1; wb_ecall = 1'b1; wb_pc = 32'h8000_1400;
        next_cycle();
        chk("rst-event trap_count", {32'd0, trap_count}, 64'd0);
        chk("rst-event busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        clear_wb();
        #2;
        chk("post-rst flush", {63'd0, flush}, 64'd0);
        next_cycle();

        // trap_count wraps from all-ones to zero
        force dut.trap_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.trap_count_reg;
        wb_valid = 1'b1; wb_ecall = 1'b1; wb_pc = 32'h8000_1500; mtvec = 64'h8000_1000;
        #1;
        chk("wrap trap_take", {63'd0, trap_take}, 64'd1);
        next_cycle();
        clear_wb();
        chk("wrap trap_count", {32'd0, trap_count}, 64'd0);
        redirect_ready = 1'b1;
        next_cycle();
        redirect_ready = 1'b0;
        chk("wrap exit busy", {63'd0, busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
